// File: rtl/regfile_dump_reader_if.sv
// Beat stream carrying one register value and its index
// from the dump reader to its consumer.
interface regfile_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] idx;

  modport master (
    output valid,
    output data,
    output idx,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  idx,
    output ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register file scan engine: walks a spare read port and
// streams index/value beats with a running XOR checksum.
module regfile_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int START_IDX = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] checksum_o,
  regfile_dump_reader_if.master out_if
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_IDX);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] oidx_q;
  logic [DATA_W-1:0] csum_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic [ADDR_W-1:0] idx_nxt;

  assign accept  = valid_q & out_if.ready;
  assign idx_nxt = idx_q + ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rf_addr_q <= '0;
      data_q    <= '0;
      oidx_q    <= '0;
      csum_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          rf_addr_q <= '0;
          if (start_i && !abort_i) begin
            idx_q     <= FIRST;
            rf_addr_q <= FIRST;
            csum_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (abort_i) begin
            rf_addr_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            data_q  <= rf_data_i;
            oidx_q  <= idx_q;
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          // An aborted beat is dropped even if the consumer took it.
          if (abort_i) begin
            valid_q   <= 1'b0;
            rf_addr_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (accept) begin
            csum_q  <= csum_q ^ data_q;
            valid_q <= 1'b0;
            if (idx_q == LAST) begin
              rf_addr_q <= '0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              idx_q     <= idx_nxt;
              rf_addr_q <= idx_nxt;
              state_q   <= LOAD;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rf_addr_o   = rf_addr_q;
  assign checksum_o  = csum_q;
  assign out_if.valid = valid_q;
  assign out_if.data  = data_q;
  assign out_if.idx   = oidx_q;

endmodule
